// File: rtl/player_input_decoder_pkg.sv
// Shared definitions for the per-player input decoder: key bit layout,
// step FSM encoding and the axis resolution helper.
package player_input_decoder_pkg;

    localparam int KEY_UP          = 0;
    localparam int KEY_DOWN        = 1;
    localparam int KEY_LEFT        = 2;
    localparam int KEY_RIGHT       = 3;
    localparam int KEY_BOMB        = 4;
    localparam int KEYS_PER_PLAYER = 5;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    typedef struct packed {
        logic dir;
        logic mov;
    } axis_t;

    // dir=0 selects the negative key (left/up), dir=1 the positive key (right/down).
    // With both held, the freshest rise wins; a simultaneous rise favours positive.
    function automatic axis_t resolve_axis(
        input logic neg_held,
        input logic pos_held,
        input logic neg_rise,
        input logic pos_rise,
        input logic dir_prev
    );
        axis_t a;
        a.mov = neg_held | pos_held;
        a.dir = dir_prev;
        if (pos_held && !neg_held) begin
            a.dir = 1'b1;
        end else if (neg_held && !pos_held) begin
            a.dir = 1'b0;
        end else if (neg_held && pos_held) begin
            if (pos_rise) begin
                a.dir = 1'b1;
            end else if (neg_rise) begin
                a.dir = 1'b0;
            end
        end
        return a;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Width for the shared repeat/cooldown counters; never narrower than one bit.
    function automatic int cnt_width(input int rep_delay, input int rep_period, input int cooldown);
        int m;
        m = max3(rep_delay, rep_period, cooldown + 1);
        if (m < 2) begin
            m = 2;
        end
        return $clog2(m);
    endfunction

endpackage

// File: rtl/player_input_decoder_channel.sv
// One player's channel: key edge detect, last-pressed-wins axis resolution,
// step pulse with auto-repeat, and bomb pulse with cooldown.
module player_input_channel
    import player_input_decoder_pkg::*;
#(
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000,
    parameter int BOMB_COOLDOWN = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable_i,
    input  logic [4:0] key_held_i,
    output logic       xdir_o,
    output logic       xmov_o,
    output logic       ydir_o,
    output logic       ymov_o,
    output logic       step_o,
    output logic       bomb_o
);

    localparam int CNT_W = cnt_width(REPEAT_DELAY, REPEAT_PERIOD, BOMB_COOLDOWN);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] COOL_INIT   = CNT_W'(BOMB_COOLDOWN);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [4:0]       key_q;
    logic [4:0]       rise;
    axis_t            x_axis;
    axis_t            y_axis;
    logic             move_held;
    logic             move_rise;

    logic             xdir_q, xdir_d;
    logic             xmov_q, xmov_d;
    logic             ydir_q, ydir_d;
    logic             ymov_q, ymov_d;
    logic             step_q, step_d;
    logic             bomb_q, bomb_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cool_q, cool_d;

    always_comb begin
        rise      = key_held_i & ~key_q;
        move_held = key_held_i[KEY_UP] | key_held_i[KEY_DOWN]
                  | key_held_i[KEY_LEFT] | key_held_i[KEY_RIGHT];
        move_rise = rise[KEY_UP] | rise[KEY_DOWN] | rise[KEY_LEFT] | rise[KEY_RIGHT];

        // Direction tracking keeps running while the game is disabled.
        x_axis = resolve_axis(key_held_i[KEY_LEFT], key_held_i[KEY_RIGHT],
                              rise[KEY_LEFT], rise[KEY_RIGHT], xdir_q);
        y_axis = resolve_axis(key_held_i[KEY_UP], key_held_i[KEY_DOWN],
                              rise[KEY_UP], rise[KEY_DOWN], ydir_q);
        xdir_d = x_axis.dir;
        ydir_d = y_axis.dir;
        xmov_d = enable_i & x_axis.mov;
        ymov_d = enable_i & y_axis.mov;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = 1'b0;
        if (!enable_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (move_held) begin
                        state_d = ST_DELAY;
                        cnt_d   = '0;
                        step_d  = 1'b1;
                    end
                end
                ST_DELAY: begin
                    if (!move_held) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (move_rise) begin
                        cnt_d  = '0;
                        step_d = 1'b1;
                    end else if (cnt_q == DELAY_LAST) begin
                        state_d = ST_REPEAT;
                        cnt_d   = '0;
                        step_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_REPEAT: begin
                    if (!move_held) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (move_rise) begin
                        state_d = ST_DELAY;
                        cnt_d   = '0;
                        step_d  = 1'b1;
                    end else if (cnt_q == PERIOD_LAST) begin
                        cnt_d  = '0;
                        step_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Presses during cooldown are discarded, not remembered for later.
    always_comb begin
        bomb_d = 1'b0;
        cool_d = cool_q;
        if (!enable_i) begin
            cool_d = '0;
        end else if (rise[KEY_BOMB] && (cool_q == '0)) begin
            bomb_d = 1'b1;
            cool_d = COOL_INIT;
        end else if (cool_q != '0) begin
            cool_d = cool_q - CNT_ONE;
        end
    end

    // key_q tracks the inputs during reset so keys held through it give no edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            key_q   <= key_held_i;
            xdir_q  <= 1'b0;
            xmov_q  <= 1'b0;
            ydir_q  <= 1'b0;
            ymov_q  <= 1'b0;
            step_q  <= 1'b0;
            bomb_q  <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cool_q  <= '0;
        end else begin
            key_q   <= key_held_i;
            xdir_q  <= xdir_d;
            xmov_q  <= xmov_d;
            ydir_q  <= ydir_d;
            ymov_q  <= ymov_d;
            step_q  <= step_d;
            bomb_q  <= bomb_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cool_q  <= cool_d;
        end
    end

    assign xdir_o = xdir_q;
    assign xmov_o = xmov_q;
    assign ydir_o = ydir_q;
    assign ymov_o = ymov_q;
    assign step_o = step_q;
    assign bomb_o = bomb_q;

endmodule

// File: rtl/player_input_decoder.sv
// Multi-player input decoder: one independent channel per player, each fed
// its own 5-bit slice of the held-key vector.
module player_input_decoder
    import player_input_decoder_pkg::*;
#(
    parameter int NUM_PLAYERS   = 2,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000,
    parameter int BOMB_COOLDOWN = 50_000_000
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   enable,
    input  logic [KEYS_PER_PLAYER*NUM_PLAYERS-1:0] key_held,
    output logic [NUM_PLAYERS-1:0]                 xdir,
    output logic [NUM_PLAYERS-1:0]                 xmov,
    output logic [NUM_PLAYERS-1:0]                 ydir,
    output logic [NUM_PLAYERS-1:0]                 ymov,
    output logic [NUM_PLAYERS-1:0]                 step,
    output logic [NUM_PLAYERS-1:0]                 bomb
);

    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
        player_input_channel #(
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .BOMB_COOLDOWN (BOMB_COOLDOWN)
        ) u_channel (
            .clock      (clock),
            .reset      (reset),
            .enable_i   (enable),
            .key_held_i (key_held[gi*KEYS_PER_PLAYER +: KEYS_PER_PLAYER]),
            .xdir_o     (xdir[gi]),
            .xmov_o     (xmov[gi]),
            .ydir_o     (ydir[gi]),
            .ymov_o     (ymov[gi]),
            .step_o     (step[gi]),
            .bomb_o     (bomb[gi])
        );
    end

endmodule

// File: doc/player_input_decoder.md
# player_input_decoder

Parametrised per-player input decoder between the PS/2 keyboard tracker and the game logic. For NUM_PLAYERS players it turns raw held-key levels into registered movement direction/enable levels with last-pressed-wins resolution, a movement step pulse with keyboard-style auto-repeat, and an edge-triggered bomb pulse with per-player cooldown. It is the generalised successor to the fixed two-player combinational decoder and adds a game-enable gate.

## Interface
Parameters:
- NUM_PLAYERS, 2, number of independent player channels (≥1)
- REPEAT_DELAY, 25_000_000, cycles from first step to first auto-repeat step (≥1)
- REPEAT_PERIOD, 5_000_000, cycles between auto-repeat steps (≥1)
- BOMB_COOLDOWN, 50_000_000, cycles after a bomb pulse during which new bomb presses are ignored (≥0)

Ports:
- clock  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- enable  in  1  game running; low gates all movement/step/bomb outputs
- key_held  in  5*NUM_PLAYERS  held-key levels; player p at bits [5p+4:5p], order {bomb, right, left, down, up}
- xdir  out  NUM_PLAYERS  0 left, 1 right
- xmov  out  NUM_PLAYERS  1 while a horizontal key is held
- ydir  out  NUM_PLAYERS  0 up, 1 down
- ymov  out  NUM_PLAYERS  1 while a vertical key is held
- step  out  NUM_PLAYERS  one-cycle movement pulse (press and auto-repeat)
- bomb  out  NUM_PLAYERS  one-cycle bomb placement pulse

## Operation
- Per cycle: key_q <= key_held; rise = key_held & ~key_q. During reset key_q loads key_held, so keys held through reset produce no edge.
- Axis resolution (x: left/right, y: up/down), independent per axis:
  - one key held: dir = that key, mov = 1
  - both held: dir = key with most recent rise; both rising the same cycle: right/down wins (dir = 1)
  - releasing the most recent key while the other stays held: dir switches to the held key
  - neither held: mov = 0, dir holds last value
- Step FSM per player, states IDLE, DELAY, REPEAT, counter cnt:
  - IDLE: any movement key held -> DELAY, cnt = 0, step = 1
  - DELAY: no movement key held -> IDLE; any movement rise -> step = 1, cnt = 0, stay; cnt == REPEAT_DELAY-1 -> step = 1, REPEAT, cnt = 0; else cnt++
  - REPEAT: no movement key held -> IDLE; any movement rise -> step = 1, DELAY, cnt = 0; cnt == REPEAT_PERIOD-1 -> step = 1, cnt = 0; else cnt++
  - release alone never pulses step
- Bomb: rise on bomb key while cooldown == 0 -> bomb = 1 for one cycle, cooldown = BOMB_COOLDOWN; cooldown decrements to 0 and saturates; rises during cooldown are dropped, not queued; a held key never retriggers.
- enable low: xmov, ymov, step, bomb forced 0; FSMs forced to IDLE; cooldowns cleared; key_q and dir tracking continue. On enable rise, held movement keys enter DELAY with a step pulse; a held bomb key does not fire.
- Players fully independent; no cross-player interaction.
- Counter widths: $clog2 of the largest of REPEAT_DELAY, REPEAT_PERIOD, BOMB_COOLDOWN+1.

## Timing
- All outputs registered. Key change sampled at the end of cycle n is visible in cycle n+1.
- Reset: all outputs 0, FSMs IDLE, cnt 0, cooldown 0. Reset mid-operation aborts repeat and cooldown immediately.
- Constant hold from cycle n: step at n+1, n+1+REPEAT_DELAY, then every REPEAT_PERIOD.
- Bomb pulse at n+1; cooldown reaches 0 in cycle n+1+BOMB_COOLDOWN; a rise sampled in that cycle is accepted.

## Structure
- Shared package: key bit indices (KEY_UP=0, KEY_DOWN=1, KEY_LEFT=2, KEY_RIGHT=3, KEY_BOMB=4), KEYS_PER_PLAYER=5, step FSM state encoding.
- Sub-module player_input_channel: one player's edge detect, axis resolution, step FSM and bomb cooldown. Top instantiates NUM_PLAYERS copies via generate and slices key_held.

## Test plan
NUM_PLAYERS=2, REPEAT_DELAY=4, REPEAT_PERIOD=2, BOMB_COOLDOWN=3.
- Reset with keys held, then release reset -> all outputs 0 in the reset cycle; no bomb pulse after release; held movement starts DELAY with a step one cycle later.
- P0 holds right for cycles 10–19 -> xmov=1, xdir=1 for cycles 11–20; step at 11, 15, 17, 19; xmov=0 at 21; xdir stays 1.
- P0 holds left from 10, adds right at 13, releases right at 16 -> xdir 0 at 11, 1 at 14 with step at 14 (DELAY restart), 0 at 17 with no step.
- P1 presses up and down in the same cycle 20 -> ydir=1, ymov=1, one step at 21; P0 outputs unchanged.
- P0 bomb pressed 10, released 11, pressed 12, released 13, pressed 16 -> bomb pulses at 11 and 17 only.
- enable low during cycles 10–14 with P0 right held -> xmov/step 0 during 11–15; step at 16 after enable returns at 15; bomb held across enable rise -> no pulse.
